// File: rtl/dmem_mmio_if.sv
// Core-to-data-memory bus: write strobe, byte address, store data and same-cycle read data.
// Combinational read path, writes commit on the next clock; no backpressure.
interface dmem_mmio_if;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  modport master (output MemWrite, output ALUResult, output WriteData, input ReadData);
  modport slave  (input MemWrite, input ALUResult, input WriteData, output ReadData);
endinterface

// File: rtl/dmem_mmio.sv
// Data-memory stage: word RAM plus MMIO LED/prescaled timer; compare IRQ under DMEM_MMIO_TIMER_IRQ_EN.
// Reads are combinational (zero latency), writes commit on the next rising clk; never stalls the core.
module dmem_mmio #(
  parameter int RAM_WORDS = 64,
  parameter int LED_WIDTH = 8,
  parameter int PRESCALE  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  dmem_mmio_if.slave           bus,
  output logic [LED_WIDTH-1:0] leds,
  output logic                 timer_irq
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  localparam logic [29:0] A_LED  = 30'h2000_0000;
  localparam logic [29:0] A_CNT  = 30'h2000_0001;

  logic [31:0]          ram_q [RAM_WORDS];
  logic [LED_WIDTH-1:0] leds_q, leds_d;
  logic [31:0]          count_q, count_d;
  logic [PW-1:0]        presc_q, presc_d;
  logic                 tick;

  logic          is_mmio;
  logic [29:0]   mmio_word;
  logic [AW-1:0] word_idx;
  logic          sel_led, sel_cnt;
  logic          wr_ram, wr_led, wr_cnt;
  logic          unused_addr_bits;

  assign is_mmio   = bus.ALUResult[31];
  assign mmio_word = bus.ALUResult[31:2];
  assign word_idx  = bus.ALUResult[AW+1:2];
  assign unused_addr_bits = ^bus.ALUResult[1:0];

  assign sel_led = is_mmio && (mmio_word == A_LED);
  assign sel_cnt = is_mmio && (mmio_word == A_CNT);
  assign wr_ram  = bus.MemWrite && !is_mmio;
  assign wr_led  = bus.MemWrite && sel_led;
  assign wr_cnt  = bus.MemWrite && sel_cnt;

  assign tick = (presc_q == PS_LAST);

  always_ff @(posedge clk) begin
    if (wr_ram) begin
      ram_q[word_idx] <= bus.WriteData;
    end
  end

  // A core write to the count wins over a tick and restarts the prescale period.
  always_comb begin
    leds_d  = leds_q;
    count_d = count_q;
    presc_d = presc_q;
    if (wr_led) begin
      leds_d = bus.WriteData[LED_WIDTH-1:0];
    end
    if (wr_cnt) begin
      count_d = bus.WriteData;
      presc_d = '0;
    end else if (tick) begin
      count_d = count_q + 32'd1;
      presc_d = '0;
    end else begin
      presc_d = presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      leds_q  <= '0;
      count_q <= '0;
      presc_q <= '0;
    end else begin
      leds_q  <= leds_d;
      count_q <= count_d;
      presc_q <= presc_d;
    end
  end

  assign leds = leds_q;

`ifdef DMEM_MMIO_TIMER_IRQ_EN
  localparam logic [29:0] A_CMP  = 30'h2000_0002;
  localparam logic [29:0] A_STAT = 30'h2000_0003;

  logic [31:0] cmp_q, cmp_d;
  logic        flag_q, flag_d;
  logic        sel_cmp, sel_stat, match_set;

  assign sel_cmp  = is_mmio && (mmio_word == A_CMP);
  assign sel_stat = is_mmio && (mmio_word == A_STAT);

  // Match is an event on the edge the count is loaded, so a stalled count cannot re-arm a cleared flag.
  assign match_set = (wr_cnt || tick) && (count_d == cmp_q);

  always_comb begin
    cmp_d  = cmp_q;
    flag_d = flag_q;
    if (bus.MemWrite && sel_cmp) begin
      cmp_d = bus.WriteData;
    end
    if (match_set) begin
      flag_d = 1'b1;
    end else if (bus.MemWrite && sel_stat && bus.WriteData[0]) begin
      flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmp_q  <= 32'hFFFF_FFFF;
      flag_q <= 1'b0;
    end else begin
      cmp_q  <= cmp_d;
      flag_q <= flag_d;
    end
  end

  assign timer_irq = flag_q;

  always_comb begin
    bus.ReadData = '0;
    if (!is_mmio) begin
      bus.ReadData = ram_q[word_idx];
    end else if (sel_led) begin
      bus.ReadData = 32'(leds_q);
    end else if (sel_cnt) begin
      bus.ReadData = count_q;
    end else if (sel_cmp) begin
      bus.ReadData = cmp_q;
    end else if (sel_stat) begin
      bus.ReadData = {31'b0, flag_q};
    end
  end
`else
  assign timer_irq = 1'b0;

  always_comb begin
    bus.ReadData = '0;
    if (!is_mmio) begin
      bus.ReadData = ram_q[word_idx];
    end else if (sel_led) begin
      bus.ReadData = 32'(leds_q);
    end else if (sel_cnt) begin
      bus.ReadData = count_q;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_mmio.sv
// Scoreboard bench for dmem_mmio: two instances (PRESCALE=4 and PRESCALE=1) share clock and reset.
// Stimulus pushes expectations; a negedge monitor pops and compares one per cycle.
module tb_dmem_mmio;

  localparam logic [31:0] A_LED  = 32'h8000_0000;
  localparam logic [31:0] A_CNT  = 32'h8000_0004;
  localparam logic [31:0] A_CMP  = 32'h8000_0008;
  localparam logic [31:0] A_STAT = 32'h8000_000C;
  localparam logic [31:0] A_UNM  = 32'h8000_0020;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] leds4, leds1;
  logic       irq4, irq1;

  dmem_mmio_if bus4();
  dmem_mmio_if bus1();

  dmem_mmio #(.RAM_WORDS(64), .LED_WIDTH(8), .PRESCALE(4)) u_dut4 (
    .clk(clk), .reset(reset), .bus(bus4), .leds(leds4), .timer_irq(irq4)
  );

  dmem_mmio #(.RAM_WORDS(64), .LED_WIDTH(8), .PRESCALE(1)) u_dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .leds(leds1), .timer_irq(irq1)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // sel: 0 rdata4, 1 leds4, 2 rdata1, 3 irq1, 4 irq4, 5 leds1
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t        e;
      logic [31:0] act;
      e = exp_q.pop_front();
      case (e.sel)
        0:       act = bus4.ReadData;
        1:       act = {24'b0, leds4};
        2:       act = bus1.ReadData;
        3:       act = {31'b0, irq1};
        4:       act = {31'b0, irq4};
        default: act = {24'b0, leds1};
      endcase
      total = total + 1;
      if (act !== e.val) begin
        bad = bad + 1;
        $display("FAIL %s: got %h want %h", e.name, act, e.val);
      end
    end
  end

  task automatic push(input int s, input logic [31:0] v, input string nm);
    exp_t e;
    e.name = nm;
    e.sel  = s;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit d, input logic we, input logic [31:0] a, input logic [31:0] wd);
    if (d) begin
      bus1.MemWrite = we; bus1.ALUResult = a; bus1.WriteData = wd;
    end else begin
      bus4.MemWrite = we; bus4.ALUResult = a; bus4.WriteData = wd;
    end
  endtask

  task automatic wr(input bit d, input logic [31:0] a, input logic [31:0] wd);
    drive(d, 1'b1, a, wd);
    tick();
    drive(d, 1'b0, a, 32'h0);
  endtask

  task automatic rd(input bit d, input logic [31:0] a, input logic [31:0] v, input string nm);
    drive(d, 1'b0, a, 32'h0);
    push(d ? 2 : 0, v, nm);
    tick();
  endtask

  task automatic chk(input int s, input logic [31:0] v, input string nm);
    push(s, v, nm);
    tick();
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 32'h0, 32'h0);
    tick();

    chk(1, 32'h0, "rst_leds4");
    chk(5, 32'h0, "rst_leds1");
    chk(4, 32'h0, "rst_irq4");
    chk(3, 32'h0, "rst_irq1");
    rd(1'b0, A_CNT, 32'h0, "rst_count4");
`ifdef DMEM_MMIO_TIMER_IRQ_EN
    rd(1'b1, A_CMP, 32'hFFFF_FFFF, "rst_cmp1");
`else
    rd(1'b1, A_CMP, 32'h0, "rst_cmp1_absent");
`endif

    // Timer with PRESCALE=4: one increment per four edges.
    reset = 1'b0;
    repeat (40) tick();
    rd(1'b0, A_CNT, 32'd10, "count_40cyc");
    wr(1'b0, A_CNT, 32'hFFFF_FFFE);
    repeat (4) tick();
    rd(1'b0, A_CNT, 32'hFFFF_FFFF, "count_pre_wrap");
    repeat (3) tick();
    rd(1'b0, A_CNT, 32'h0, "count_wrap");
    repeat (2) tick();
    wr(1'b0, A_CNT, 32'd100);
    rd(1'b0, A_CNT, 32'd100, "wr_wins_tick");
    wr(1'b0, A_CNT, 32'd200);
    repeat (2) tick();
    rd(1'b0, A_CNT, 32'd200, "presc_cleared");
    tick();
    rd(1'b0, A_CNT, 32'd201, "presc_next_tick");

    // RAM and decode
    wr(1'b0, 32'h0000_0010, 32'hDEAD_BEEF);
    wr(1'b0, 32'h0000_0014, 32'h1234_5678);
    rd(1'b0, 32'h0000_0010, 32'hDEAD_BEEF, "ram_10");
    rd(1'b0, 32'h0000_0014, 32'h1234_5678, "ram_14");
    rd(1'b0, 32'h0000_0110, 32'hDEAD_BEEF, "ram_alias");
    rd(1'b0, 32'h0000_0013, 32'hDEAD_BEEF, "ram_lowbits");
    rd(1'b0, 32'h8000_0010, 32'h0, "mmio_not_ram");

    // LED register
    wr(1'b0, A_LED, 32'h0000_01A5);
    chk(1, 32'hA5, "leds_a5");
    rd(1'b0, A_LED, 32'h0000_00A5, "led_read");

    // Unmapped MMIO
    wr(1'b0, 32'h0000_0020, 32'hCAFE_F00D);
    rd(1'b0, A_UNM, 32'h0, "unmapped_rd");
    wr(1'b0, A_UNM, 32'hFFFF_FFFF);
    chk(1, 32'hA5, "unmapped_leds");
    rd(1'b0, 32'h0000_0020, 32'hCAFE_F00D, "unmapped_ram");
    rd(1'b0, A_UNM, 32'h0, "unmapped_rd2");

    // Reset mid-cycle with an LED write pending
    drive(1'b0, 1'b1, A_LED, 32'h0000_003C);
    #2;
    reset = 1'b1;
    push(1, 32'h0, "async_rst_leds");
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, A_CNT, 32'h0);
    chk(1, 32'h0, "rst_write_lost");
    rd(1'b0, A_CNT, 32'h0, "rst_count_again");
    reset = 1'b0;

`ifdef DMEM_MMIO_TIMER_IRQ_EN
    wr(1'b1, A_CMP, 32'd20);
    wr(1'b1, A_CNT, 32'd0);
    repeat (19) tick();
    chk(3, 32'h0, "irq_before_match");
    chk(3, 32'h1, "irq_match");
    rd(1'b1, A_STAT, 32'h1, "status_set");
    rd(1'b1, A_CMP, 32'd20, "cmp_read");
    wr(1'b1, A_STAT, 32'h0);
    chk(3, 32'h1, "irq_wr0_noclear");
    wr(1'b1, A_STAT, 32'h1);
    chk(3, 32'h0, "irq_cleared");
    wr(1'b1, A_CNT, 32'd10);
    repeat (9) tick();
    wr(1'b1, A_STAT, 32'h1);
    chk(3, 32'h1, "set_wins_clear");
    chk(3, 32'h1, "irq_sticky");
    wr(1'b1, A_STAT, 32'h1);
    chk(3, 32'h0, "irq_cleared2");
    wr(1'b1, A_CNT, 32'd20);
    chk(3, 32'h1, "irq_match_by_write");
`else
    wr(1'b1, A_CMP, 32'd5);
    wr(1'b1, A_CNT, 32'd0);
    repeat (10) tick();
    rd(1'b1, A_CMP, 32'h0, "cmp_absent");
    rd(1'b1, A_STAT, 32'h0, "status_absent");
    chk(3, 32'h0, "irq_tied_low");
    rd(1'b1, A_CNT, 32'd13, "count1_running");
`endif

    for (int i = 0; i < 5; i++) begin
      if (exp_q.size() != 0) tick();
    end
    if (exp_q.size() != 0) begin
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
      total = total + 1;
      bad   = bad + 1;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_mmio.md
Name: dmem_mmio

Overview:
- Data-side memory stage directly downstream of the single-cycle RISC-V core.
- Consumes the core's MemWrite, ALUResult (address) and WriteData; returns ReadData in the same cycle.
- Holds word-addressed data RAM plus a small memory-mapped I/O block: LED register, free-running prescaled timer, optional compare/interrupt.
- Sits beside instruction memory in the top-level; drives board LEDs and an interrupt line.

Parameters:
- RAM_WORDS, 64, data RAM depth in 32-bit words; power of two, minimum 4.
- LED_WIDTH, 8, width of LED output register; 1..32.
- PRESCALE, 1, clock cycles per timer increment; 1..65535.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- MemWrite  input  1  write strobe from core; write committed at the next rising clk.
- ALUResult  input  32  byte address from core; bits [1:0] ignored (word access only).
- WriteData  input  32  store data from core.
- ReadData  output  32  combinational read data for the current ALUResult.
- leds  output  LED_WIDTH  LED register contents.
- timer_irq  output  1  timer match flag, level output.

Behaviour:
- Address decode:
  - ALUResult[31]=0 → RAM, word index ALUResult[log2(RAM_WORDS)+1:2]; higher bits ignored, so addresses alias/wrap.
  - ALUResult[31]=1 → MMIO, decoded on ALUResult[31:2] exact match:
    - 0x8000_0000 LED register, R/W; reads return zero-extended leds.
    - 0x8000_0004 TIMER_COUNT, R/W 32-bit.
    - 0x8000_0008 TIMER_CMP, R/W 32-bit (optional feature).
    - 0x8000_000C STATUS; bit0 = match flag, write-1-to-clear (optional feature).
    - Any other MMIO address: reads 0, writes ignored.
- Reads: purely combinational, zero latency. Required because the core is single-cycle.
- Writes: when MemWrite=1, the target updates at the rising clk; the new value is visible on ReadData in the following cycle.
- RAM: not reset; contents undefined after power-up. A write does not alter any other word.
- Reset values (asynchronous):
  - leds = 0
  - TIMER_COUNT = 0
  - prescale counter = 0
  - TIMER_CMP = 0xFFFF_FFFF
  - match flag = 0
  - timer_irq = 0
  - ReadData follows the decode of the reset register values.
- Prescaler:
  - Counts 0..PRESCALE-1, then wraps to 0 and issues a one-cycle tick.
  - PRESCALE=1 gives a tick every cycle.
- TIMER_COUNT:
  - Increments by 1 on each tick, modulo 2^32; 0xFFFF_FFFF wraps to 0 with no flag.
  - A core write to TIMER_COUNT in the same cycle as a tick: write wins, no increment that cycle.
  - A core write also clears the prescale counter.
- Reset mid-operation: all registers return to reset values immediately, independent of clk. A write in progress is lost.

Optional Feature:
- Macro: DMEM_MMIO_TIMER_IRQ_EN.
- Defined:
  - TIMER_CMP and STATUS are implemented.
  - On the clock edge where TIMER_COUNT takes the value equal to TIMER_CMP (by increment or by write), the match flag sets.
  - The flag is sticky.
  - Writing STATUS with bit0=1 clears it. If set and clear occur in the same cycle, set wins.
  - timer_irq = match flag.
- Undefined:
  - TIMER_CMP and STATUS read 0 and ignore writes.
  - No compare logic is built; timer_irq tied to 0.
  - All other behaviour is unchanged.

Test Plan:
- Reset, then write 0xDEADBEEF to 0x0000_0010 and 0x12345678 to 0x0000_0014; read both → exact values returned. Read 0x0000_0110 (RAM_WORDS=64) → 0xDEADBEEF (alias).
- Write 0x0000_01A5 to 0x8000_0000 → leds=0xA5 next cycle; read returns 0x0000_00A5. Assert reset mid-cycle → leds=0 immediately.
- PRESCALE=4, release reset, run 40 cycles → TIMER_COUNT reads 10. Write 0xFFFF_FFFE, run 8 cycles → reads 0x0000_0000 (wrap).
- Write TIMER_COUNT=100 on the same edge a tick occurs → reads 100, not 101. Read unmapped 0x8000_0020 → 0; write to it has no effect on any register.
- With DMEM_MMIO_TIMER_IRQ_EN, PRESCALE=1:
  - Write TIMER_CMP=20, then TIMER_COUNT=0 → timer_irq rises on the edge where count becomes 20 and stays high.
  - Write 1 to 0x8000_000C → timer_irq low next cycle.
  - Clear written on the match edge → timer_irq stays high.
- Without DMEM_MMIO_TIMER_IRQ_EN: write 5 to TIMER_CMP, run past count 5 → 0x8000_0008 reads 0, timer_irq remains 0.
